spraid_stripe_sched: RTL and testbench
======================================

# spraid_stripe_sched

Stripe scheduler sitting between the wishbone register front-end and the four SPI channel engines of the spraid array. It splits one logical block transfer (read or write, 1–256 words) into per-word SPI jobs, striped RAID-0 style across channels by logical address, with up to one job in flight per channel. It returns read data and retires jobs strictly in logical order.

## Interface
- NCH, 4: channel count; fixed at 4 in this design, logical address bits [1:0] select the channel.
- AW, 24: logical word-address width; physical per-channel address is AW-2 bits.
- wb_clk_i  in  1  sole clock.
- wb_rst_n_i  in  1  reset, asynchronous, active-low.
- cmd_valid_i / cmd_ready_o  in/out  1  transfer-command handshake.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_addr_i  in  AW  logical start word address.
- cmd_len_i  in  8  word count minus one (0 → 1 word, 255 → 256).
- wdat_valid_i / wdat_ready_o  in/out  1  write-data stream handshake.
- wdat_i  in  32  write word.
- rdat_valid_o / rdat_ready_i  out/in  1  read-data stream handshake.
- rdat_o  out  32  read word, logical order.
- ch_start_o  out  NCH  one-hot, 1-cycle job-start pulse.
- ch_we_o, ch_addr_o (AW-2), ch_wdat_o (32)  out  shared job fields, valid with ch_start_o.
- ch_busy_i  in  NCH  engine busy; no start while high.
- ch_done_i  in  NCH  1-cycle job-complete pulse.
- ch_rdat_i  in  NCH*32  per-channel read word, valid with ch_done_i.
- busy_o  out  1  transfer in progress.
- done_o  out  1  1-cycle pulse at transfer end.
- err_o  out  1  sticky: ch_done_i on a channel with no job outstanding.

## Operation
- States IDLE, RUN, FIN. Reset → IDLE; all outputs 0 except cmd_ready_o=1.
- IDLE: cmd_ready_o=1. On accept latch we, addr, len; clear issue count, retire count, err_o; → RUN.
- RUN, issue (max one per cycle): word k = issue count; ch = (addr+k)[1:0]; phys = (addr+k)[AW-1:2], wrap modulo 2^AW. Issue when k ≤ len, slot[ch] not outstanding, ch_busy_i[ch]=0, and (read, or wdat_valid_i=1). Issue pulses ch_start_o[ch], sets slot outstanding; writes assert wdat_ready_o the same cycle (wdat_ready_o never high otherwise).
- Completion: ch_done_i[ch] on outstanding slot sets slot complete, reads capture ch_rdat_i into slot register. Multiple channels may complete in one cycle.
- Retire (max one per cycle, in logical order): slot at retire pointer complete → writes retire immediately; reads present rdat_valid_o and retire on rdat_ready_i. Retire clears the slot, increments retire count.
- Slot freed by retire is not reusable in the same cycle (no bypass); issue and retire on different channels may coincide.
- Retire count reaching len+1 → FIN: done_o=1 for one cycle, → IDLE.
- Reset mid-transfer: all slots, counts, streams dropped; no further ch_start_o; engines are reset by the same reset.

## Timing
- cmd accept at cycle t → earliest ch_start_o at t+1.
- ch_done_i at t → rdat_valid_o earliest t+1 (registered), held until rdat_ready_i.
- Steady-state read with idle engines and rdat_ready_i=1: one issue per cycle for first 4 words, then bounded by engine latency.
- Final retire at t → done_o at t+1; cmd_ready_o at t+2.
- busy_o = (state ≠ IDLE).

## Structure
- Package spraid_pkg: NCH, AW defaults, state enum, channel-index typedef, 32-bit word typedef.
- Sub-module spraid_ch_slot: outstanding/complete flags plus read-data register; instantiated NCH times.

## Test plan
- Read, addr=0x000001, len=5 (6 words), engines 3-cycle latency → starts on ch 1,2,3,0,1,2 with phys 0,0,0,1,1,1; rdat_o in logical order; done_o once.
- Write, len=3, wdat_valid_i toggling every other cycle → exactly 4 wdat handshakes, ch_wdat_o matches word sequence, no start without data.
- Out-of-order completion: ch 2 done before ch 1 → rdat_o still ch1 then ch2 data.
- rdat_ready_i held low 20 cycles, len=7 → at most 4 starts before stall, none lost.
- Address wrap: addr=0xFFFFFE, len=3 → phys 0x3FFFFF, 0x3FFFFF, 0x000000, 0x000000 on ch 2,3,0,1.
- Spurious ch_done_i[3] in IDLE → err_o=1 sticky; cleared on next cmd accept. Reset asserted mid-read → outputs to reset values within one cycle.

Source files
------------

// File: rtl/spraid_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spraid_pkg                                                               |
// | Shared constants and types for the spraid stripe scheduler.              |
// |   NCH_DEF / AW_DEF : default channel count and logical address width    |
// |   state_t, ST_*    : scheduler state encoding                            |
// |   ch_idx_t         : channel index (logical address bits [1:0])          |
// |   word_t           : 32-bit data word                                    |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package spraid_pkg;

   localparam int NCH_DEF = 4;
   localparam int AW_DEF  = 24;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_RUN  = 2'd1;
   localparam state_t ST_FIN  = 2'd2;

   typedef logic [1:0]  ch_idx_t;
   typedef logic [31:0] word_t;

endpackage
`default_nettype wire

// File: rtl/spraid_ch_slot.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spraid_ch_slot                                                           |
// | Per-channel job slot: tracks one job from issue through completion to    |
// | retire and holds the read word returned by the engine.                   |
// |   clk, rst_n   : clock, asynchronous active-low reset                    |
// |   issue_i      : job started on this channel                             |
// |   done_i       : engine completion pulse                                 |
// |   cap_en_i     : capture rdat_i on completion (read transfer)            |
// |   retire_i     : job retired, slot released                              |
// |   rdat_i       : engine read word                                        |
// |   busy_o       : slot occupied (outstanding or complete)                 |
// |   cmp_o        : job complete, awaiting retire                           |
// |   spur_o       : completion seen with no job outstanding                 |
// |   rdat_o       : captured read word                                      |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module spraid_ch_slot
   import spraid_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   input  logic  issue_i,
   input  logic  done_i,
   input  logic  cap_en_i,
   input  logic  retire_i,
   input  word_t rdat_i,
   output logic  busy_o,
   output logic  cmp_o,
   output logic  spur_o,
   output word_t rdat_o
);

   logic  out_q, out_d;
   logic  cmp_q, cmp_d;
   word_t dat_q, dat_d;

   always_comb begin
      out_d = out_q;
      cmp_d = cmp_q;
      dat_d = dat_q;
      if (issue_i) begin
         out_d = 1'b1;
      end
      if (done_i && out_q) begin
         out_d = 1'b0;
         cmp_d = 1'b1;
         if (cap_en_i) begin
            dat_d = rdat_i;
         end
      end
      if (retire_i) begin
         cmp_d = 1'b0;
         dat_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q <= 1'b0;
         cmp_q <= 1'b0;
         dat_q <= '0;
      end else begin
         out_q <= out_d;
         cmp_q <= cmp_d;
         dat_q <= dat_d;
      end
   end

   assign busy_o = out_q | cmp_q;
   assign cmp_o  = cmp_q;
   assign spur_o = done_i & ~out_q;
   assign rdat_o = dat_q;

endmodule
`default_nettype wire

// File: rtl/spraid_stripe_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spraid_stripe_sched                                                      |
// | Splits one block transfer into per-word SPI jobs striped across the      |
// | channels by logical address bits [1:0], one job in flight per channel,   |
// | and retires jobs / returns read data strictly in logical order.          |
// |   wb_clk_i, wb_rst_n_i        : clock, asynchronous active-low reset     |
// |   cmd_*                       : transfer command (we, addr, len-1)       |
// |   wdat_*                      : write-data stream in                     |
// |   rdat_*                      : read-data stream out, logical order      |
// |   ch_start_o/we/addr/wdat     : job start to the channel engines         |
// |   ch_busy_i/done_i/rdat_i     : engine status and completion             |
// |   busy_o, done_o, err_o       : transfer status                          |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module spraid_stripe_sched
   import spraid_pkg::*;
#(
   parameter int NCH = NCH_DEF,
   parameter int AW  = AW_DEF
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_n_i,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic              cmd_we_i,
   input  logic [AW-1:0]     cmd_addr_i,
   input  logic [7:0]        cmd_len_i,
   input  logic              wdat_valid_i,
   output logic              wdat_ready_o,
   input  logic [31:0]       wdat_i,
   output logic              rdat_valid_o,
   input  logic              rdat_ready_i,
   output logic [31:0]       rdat_o,
   output logic [NCH-1:0]    ch_start_o,
   output logic              ch_we_o,
   output logic [AW-3:0]     ch_addr_o,
   output logic [31:0]       ch_wdat_o,
   input  logic [NCH-1:0]    ch_busy_i,
   input  logic [NCH-1:0]    ch_done_i,
   input  logic [NCH*32-1:0] ch_rdat_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o
);

   state_t          state_q, state_d;
   logic            we_q, we_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [7:0]      len_q, len_d;
   logic [8:0]      iss_q, iss_d;     // words issued so far (0..256)
   logic [8:0]      ret_q, ret_d;     // words retired so far (0..256)
   logic            err_q, err_d;

   logic [AW-1:0]   iss_la, ret_la;
   ch_idx_t         iss_ch, ret_ch;
   logic            can_issue, can_retire, rd_present;
   logic [NCH-1:0]  slot_busy, slot_cmp, slot_spur, slot_issue, slot_retire;
   word_t           slot_rdat [NCH];

   // Logical address of the next word to issue / retire; wraps modulo 2^AW.
   assign iss_la = addr_q + AW'(iss_q);
   assign ret_la = addr_q + AW'(ret_q);
   assign iss_ch = iss_la[1:0];
   assign ret_ch = ret_la[1:0];

   // Slot occupancy is taken from registered state, so a slot released by a
   // retire this cycle cannot be reissued until the next cycle.
   assign can_issue  = (state_q == ST_RUN) && (iss_q <= {1'b0, len_q}) &&
                       !slot_busy[iss_ch] && !ch_busy_i[iss_ch] &&
                       (!we_q || wdat_valid_i);
   assign rd_present = (state_q == ST_RUN) && !we_q && slot_cmp[ret_ch];
   assign can_retire = (state_q == ST_RUN) && slot_cmp[ret_ch] &&
                       (we_q || rdat_ready_i);

   assign slot_issue  = can_issue  ? ({{(NCH-1){1'b0}}, 1'b1} << iss_ch) : '0;
   assign slot_retire = can_retire ? ({{(NCH-1){1'b0}}, 1'b1} << ret_ch) : '0;

   for (genvar i = 0; i < NCH; i++) begin : g_slot
      spraid_ch_slot u_slot (
         .clk      (wb_clk_i),
         .rst_n    (wb_rst_n_i),
         .issue_i  (slot_issue[i]),
         .done_i   (ch_done_i[i]),
         .cap_en_i (!we_q),
         .retire_i (slot_retire[i]),
         .rdat_i   (ch_rdat_i[i*32 +: 32]),
         .busy_o   (slot_busy[i]),
         .cmp_o    (slot_cmp[i]),
         .spur_o   (slot_spur[i]),
         .rdat_o   (slot_rdat[i])
      );
   end

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      addr_d  = addr_q;
      len_d   = len_q;
      iss_d   = iss_q;
      ret_d   = ret_q;
      err_d   = err_q | (|slot_spur);
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid_i) begin
               we_d    = cmd_we_i;
               addr_d  = cmd_addr_i;
               len_d   = cmd_len_i;
               iss_d   = '0;
               ret_d   = '0;
               // Accept clears the sticky error; a spurious done in the very
               // same cycle still registers.
               err_d   = |slot_spur;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (can_issue) begin
               iss_d = iss_q + 9'd1;
            end
            if (can_retire) begin
               ret_d = ret_q + 9'd1;
               if (ret_q == {1'b0, len_q}) begin
                  state_d = ST_FIN;
               end
            end
         end
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         state_q <= ST_IDLE;
         we_q    <= 1'b0;
         addr_q  <= '0;
         len_q   <= '0;
         iss_q   <= '0;
         ret_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         iss_q   <= iss_d;
         ret_q   <= ret_d;
         err_q   <= err_d;
      end
   end

   assign cmd_ready_o  = (state_q == ST_IDLE);
   assign busy_o       = (state_q != ST_IDLE);
   assign done_o       = (state_q == ST_FIN);
   assign err_o        = err_q;
   assign wdat_ready_o = can_issue & we_q;
   assign ch_start_o   = slot_issue;
   assign ch_we_o      = can_issue & we_q;
   assign ch_addr_o    = can_issue ? iss_la[AW-1:2] : '0;
   assign ch_wdat_o    = (can_issue && we_q) ? wdat_i : '0;
   assign rdat_valid_o = rd_present;
   assign rdat_o       = rd_present ? slot_rdat[ret_ch] : '0;

endmodule
`default_nettype wire

// File: tb/tb_spraid_stripe_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_spraid_stripe_sched                                                   |
// | Self-checking bench: directed table of transfers, hand-written corner    |
// | sequences and randomized transfers against a behavioural model of the    |
// | striping rules and a simple latency-programmable engine per channel.     |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_spraid_stripe_sched;

   localparam int NCH = 4;
   localparam int AW  = 24;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              cmd_valid_i, cmd_ready_o, cmd_we_i;
   logic [AW-1:0]     cmd_addr_i;
   logic [7:0]        cmd_len_i;
   logic              wdat_valid_i, wdat_ready_o;
   logic [31:0]       wdat_i;
   logic              rdat_valid_o, rdat_ready_i;
   logic [31:0]       rdat_o;
   logic [NCH-1:0]    ch_start_o;
   logic              ch_we_o;
   logic [AW-3:0]     ch_addr_o;
   logic [31:0]       ch_wdat_o;
   logic [NCH-1:0]    ch_busy_i, ch_done_i;
   logic [NCH*32-1:0] ch_rdat_i;
   logic              busy_o, done_o, err_o;

   always #5 clk = ~clk;

   spraid_stripe_sched #(.NCH(NCH), .AW(AW)) dut (
      .wb_clk_i(clk), .wb_rst_n_i(rst_n),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
      .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
      .wdat_valid_i(wdat_valid_i), .wdat_ready_o(wdat_ready_o), .wdat_i(wdat_i),
      .rdat_valid_o(rdat_valid_o), .rdat_ready_i(rdat_ready_i), .rdat_o(rdat_o),
      .ch_start_o(ch_start_o), .ch_we_o(ch_we_o), .ch_addr_o(ch_addr_o),
      .ch_wdat_o(ch_wdat_o), .ch_busy_i(ch_busy_i), .ch_done_i(ch_done_i),
      .ch_rdat_i(ch_rdat_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
   );

   int n_vec  = 0;
   int n_miss = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Engine storage content: channel id in the top bits, physical address low.
   function automatic logic [31:0] mem_word(input logic [1:0] ch, input logic [21:0] phys);
      return {ch, 8'hC3, phys};
   endfunction

   // Engine model state
   bit          eng_busy [NCH];
   int          eng_cnt  [NCH];
   logic [31:0] eng_dat  [NCH];

   task automatic eng_clear();
      for (int c = 0; c < NCH; c++) begin
         eng_busy[c] = 1'b0;
         eng_cnt[c]  = 0;
      end
      ch_busy_i = '0;
      ch_done_i = '0;
      ch_rdat_i = '0;
   endtask

   // Runs one transfer from command to done_o and checks it against the
   // striping model. Entered and left just after a rising edge.
   task automatic run_xfer(input bit we, input logic [23:0] addr, input int len,
                           input int wmode, input int rmode, input int lmode,
                           input int stall, output int stall_starts,
                           output logic [3:0] f_oh, output logic [21:0] f_phys,
                           output logic [3:0] l_oh, output logic [21:0] l_phys);
      int          k_iss = 0, k_ret = 0, cyc = 0, bad = 0;
      int          done_cyc = 0, last_ret_cyc = 0;
      bit          saw_done = 1'b0;
      logic [31:0] wbase = $urandom;
      logic [23:0] la;
      int          sc;
      stall_starts = 0;
      f_oh = '0; f_phys = '0; l_oh = '0; l_phys = '0;
      chk("cmd_ready_idle", cmd_ready_o, 1);
      cmd_valid_i = 1'b1; cmd_we_i = we; cmd_addr_i = addr; cmd_len_i = len[7:0];
      @(posedge clk); #1;
      cmd_valid_i = 1'b0;
      while (!saw_done && cyc < 4000) begin
         for (int c = 0; c < NCH; c++) begin
            ch_done_i[c] = 1'b0;
            if (eng_busy[c]) begin
               eng_cnt[c]--;
               if (eng_cnt[c] == 0) begin
                  ch_done_i[c]         = 1'b1;
                  ch_rdat_i[c*32 +: 32] = eng_dat[c];
                  eng_busy[c]          = 1'b0;
               end
            end
            ch_busy_i[c] = eng_busy[c];
         end
         wdat_valid_i = (wmode == 0) ? 1'b1 : (wmode == 1) ? ~cyc[0] : 1'($urandom_range(0, 1));
         wdat_i       = wbase + 32'(k_iss);
         rdat_ready_i = (cyc < stall) ? 1'b0 : (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         @(negedge clk);
         if (cyc == 0 && !we) chk("first_start_latency", |ch_start_o, 1);
         if (wdat_ready_o !== (we && (|ch_start_o))) bad++;
         if (we && (|ch_start_o) && !wdat_valid_i) bad++;
         if (we && rdat_valid_o) bad++;
         if (|ch_start_o) begin
            la = addr + 24'(k_iss);
            chk("start_in_range", k_iss <= len, 1);
            chk("start_ch", ch_start_o, 64'd1 << la[1:0]);
            chk("start_phys", ch_addr_o, la[23:2]);
            chk("start_we", ch_we_o, we);
            if (we) chk("start_wdat", ch_wdat_o, wbase + 32'(k_iss));
            if (k_iss == 0) begin f_oh = ch_start_o; f_phys = ch_addr_o; end
            l_oh = ch_start_o; l_phys = ch_addr_o;
            if (cyc < stall) stall_starts++;
            for (int c = 0; c < NCH; c++) begin
               if (ch_start_o[c]) begin
                  sc = c;
                  eng_busy[c] = 1'b1;
                  eng_cnt[c]  = (lmode == 0) ? 3 : (lmode == 1) ? int'($urandom_range(1, 6))
                              : ((c == 1) ? 8 : 1);
                  eng_dat[c]  = mem_word(sc[1:0], ch_addr_o);
               end
            end
            k_iss++;
         end
         if (rdat_valid_o && rdat_ready_i && !we) begin
            la = addr + 24'(k_ret);
            chk("rdat", rdat_o, mem_word(la[1:0], la[23:2]));
            k_ret++;
            last_ret_cyc = cyc;
         end
         if (done_o) begin saw_done = 1'b1; done_cyc = cyc; end
         @(posedge clk); #1;
         cyc++;
      end
      ch_done_i = '0;
      chk("done_seen", saw_done, 1);
      chk("issued_words", k_iss, len + 1);
      chk("illegal_cycles", bad, 0);
      if (!we) begin
         chk("read_words", k_ret, len + 1);
         chk("done_latency", done_cyc - last_ret_cyc, 1);
      end
      @(negedge clk);
      chk("ready_after_done", cmd_ready_o, 1);
      chk("busy_after_done", busy_o, 0);
      chk("done_single_pulse", done_o, 0);
      chk("err_clean", err_o, 0);
      @(posedge clk); #1;
   endtask

   typedef struct {
      bit          we;
      logic [23:0] addr;
      int          len, wmode, rmode, lmode, stall;
      logic [3:0]  f_oh;
      logic [21:0] f_phys;
      logic [3:0]  l_oh;
      logic [21:0] l_phys;
   } vec_t;

   vec_t tbl [8];

   initial begin
      int          ss;
      logic [3:0]  f_oh, l_oh;
      logic [21:0] f_phys, l_phys;
      cmd_valid_i = 0; cmd_we_i = 0; cmd_addr_i = '0; cmd_len_i = '0;
      wdat_valid_i = 0; wdat_i = '0; rdat_ready_i = 0;
      eng_clear();

      //          we  addr        len wm rm lm stall f_oh     f_phys     l_oh     l_phys
      tbl[0] = '{1'b0, 24'h000001,  5, 0, 0, 0,  0, 4'b0010, 22'h0,     4'b0100, 22'h1};
      tbl[1] = '{1'b1, 24'h000010,  3, 1, 0, 0,  0, 4'b0001, 22'h4,     4'b1000, 22'h4};
      tbl[2] = '{1'b0, 24'h000001,  1, 0, 0, 2,  0, 4'b0010, 22'h0,     4'b0100, 22'h0};
      tbl[3] = '{1'b0, 24'h000100,  7, 0, 0, 0, 20, 4'b0001, 22'h40,    4'b1000, 22'h41};
      tbl[4] = '{1'b1, 24'hFFFFFE,  3, 0, 0, 0,  0, 4'b0100, 22'h3FFFFF, 4'b0010, 22'h0};
      tbl[5] = '{1'b0, 24'hFFFFFE,  3, 0, 1, 1,  0, 4'b0100, 22'h3FFFFF, 4'b0010, 22'h0};
      tbl[6] = '{1'b0, 24'h000000, 255, 0, 0, 0, 0, 4'b0001, 22'h0,     4'b1000, 22'h3F};
      tbl[7] = '{1'b1, 24'h000003,  0, 2, 0, 1,  0, 4'b1000, 22'h0,     4'b1000, 22'h0};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_cmd_ready", cmd_ready_o, 1);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_start", ch_start_o, 0);
      chk("rst_rdat_valid", rdat_valid_o, 0);
      chk("rst_wdat_ready", wdat_ready_o, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 8; i++) begin
         run_xfer(tbl[i].we, tbl[i].addr, tbl[i].len, tbl[i].wmode, tbl[i].rmode,
                  tbl[i].lmode, tbl[i].stall, ss, f_oh, f_phys, l_oh, l_phys);
         chk("tbl_first_ch", f_oh, tbl[i].f_oh);
         chk("tbl_first_phys", f_phys, tbl[i].f_phys);
         chk("tbl_last_ch", l_oh, tbl[i].l_oh);
         chk("tbl_last_phys", l_phys, tbl[i].l_phys);
         if (tbl[i].stall > 0) chk("stall_starts_le4", ss <= 4, 1);
      end

      // Spurious completion while idle sets a sticky error, cleared by accept.
      @(negedge clk);
      chk("err_idle_clear", err_o, 0);
      @(posedge clk); #1;
      ch_done_i = 4'b1000;
      @(posedge clk); #1;
      ch_done_i = '0;
      @(negedge clk);
      chk("err_set", err_o, 1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("err_sticky", err_o, 1);
      @(posedge clk); #1;
      run_xfer(1'b0, 24'h000005, 2, 0, 0, 0, 0, ss, f_oh, f_phys, l_oh, l_phys);

      // Randomized transfers.
      for (int i = 0; i < 20; i++) begin
         run_xfer(1'($urandom_range(0, 1)), 24'($urandom), int'($urandom_range(0, 40)),
                  int'($urandom_range(0, 2)), int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 2)), int'($urandom_range(0, 1)) * 10,
                  ss, f_oh, f_phys, l_oh, l_phys);
      end

      // Reset asserted in the middle of a read.
      cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_addr_i = 24'h000010; cmd_len_i = 8'd20;
      @(posedge clk); #1;
      cmd_valid_i = 1'b0;
      @(negedge clk);
      chk("mid_first_start", ch_start_o, 4'b0001);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_cmd_ready", cmd_ready_o, 1);
      chk("mid_rst_busy", busy_o, 0);
      chk("mid_rst_start", ch_start_o, 0);
      chk("mid_rst_addr", ch_addr_o, 0);
      chk("mid_rst_rdat_valid", rdat_valid_o, 0);
      chk("mid_rst_done", done_o, 0);
      chk("mid_rst_err", err_o, 0);
      eng_clear();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("post_rst_no_start", ch_start_o, 0);
      chk("post_rst_idle", cmd_ready_o, 1);
      @(posedge clk); #1;
      run_xfer(1'b0, 24'h000022, 9, 0, 1, 1, 0, ss, f_oh, f_phys, l_oh, l_phys);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
`default_nettype wire
